// File: rtl/s3_pm_pkg.sv
// s3_pm_pkg
// Shared definitions for the S3 power-state sequencer and its neighbours.
//   - S3_STATE_W and the 3-bit state codes published on fsm_state.
//   - s3_state_e, the FSM state type built from those codes.
//   - Default IDLE_LIMIT / SETTLE_CYCLES values, shared with the datapath and bench.
package s3_pm_pkg;

    localparam int S3_STATE_W = 3;

    localparam logic [S3_STATE_W-1:0] ST_ACTIVE   = 3'd0;
    localparam logic [S3_STATE_W-1:0] ST_SAVE     = 3'd1;
    localparam logic [S3_STATE_W-1:0] ST_CLAMP    = 3'd2;
    localparam logic [S3_STATE_W-1:0] ST_GATE     = 3'd3;
    localparam logic [S3_STATE_W-1:0] ST_OFF      = 3'd4;
    localparam logic [S3_STATE_W-1:0] ST_POWER_UP = 3'd5;
    localparam logic [S3_STATE_W-1:0] ST_RESTORE  = 3'd6;
    localparam logic [S3_STATE_W-1:0] ST_RELEASE  = 3'd7;

    typedef enum logic [S3_STATE_W-1:0] {
        S_ACTIVE   = ST_ACTIVE,
        S_SAVE     = ST_SAVE,
        S_CLAMP    = ST_CLAMP,
        S_GATE     = ST_GATE,
        S_OFF      = ST_OFF,
        S_POWER_UP = ST_POWER_UP,
        S_RESTORE  = ST_RESTORE,
        S_RELEASE  = ST_RELEASE
    } s3_state_e;

    localparam int DEF_IDLE_LIMIT    = 10;
    localparam int DEF_SETTLE_CYCLES = 4;

endpackage

// File: rtl/s3_cycle_counter.sv
// s3_cycle_counter
// Generic up-counter with clear, enable, saturation at all-ones, and a
// terminal compare against a limit supplied at run time.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clr         - clear to zero on the next edge (priority over en)
//   en          - count up by one, holding once all-ones is reached
//   limit       - terminal value for the compare
//   count       - current count
//   at_limit    - high while count >= limit
module s3_cycle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    // >= rather than == so a saturated count still reads as terminal.
    assign at_limit = (count_q >= limit);

endmodule

// File: rtl/s3_sequencer.sv
// s3_sequencer
// Central S3 power-state sequencer. Enters S3 on a software request or after
// IDLE_LIMIT consecutive idle cycles, walks save -> clamp -> gate -> off, and
// on wake walks power-up settle -> RAM restore -> isolation release.
// All outputs are decoded from registered state only.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   idle           - ALU idle indication
//   sleep_req      - level request to enter S3
//   wake_req       - level wake event (wins over sleep_req)
//   s3_state       - high during the save/retain phase
//   ram_we         - RAM write enable (store in SAVE, restore in RESTORE)
//   clk_gate       - gate the datapath clock
//   iso_clampn     - active-low isolation clamp
//   reset_assert   - hold the datapath in reset
//   pg_down        - power-gate switch off
//   restore_valid  - one-cycle pulse once RAM outputs hold restored data
//   sleeping       - high only in OFF
//   fsm_state      - current state code
module s3_sequencer
    import s3_pm_pkg::*;
#(
    parameter int IDLE_LIMIT    = DEF_IDLE_LIMIT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idle,
    input  logic                  sleep_req,
    input  logic                  wake_req,
    output logic                  s3_state,
    output logic                  ram_we,
    output logic                  clk_gate,
    output logic                  iso_clampn,
    output logic                  reset_assert,
    output logic                  pg_down,
    output logic                  restore_valid,
    output logic                  sleeping,
    output logic [S3_STATE_W-1:0] fsm_state
);

    // Terminal counts are one less than the cycle totals: the compare is made
    // against the count of samples already taken, before the current one.
    localparam logic [CNT_W-1:0] IDLE_TERM   = CNT_W'(IDLE_LIMIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);

    s3_state_e state_q;
    s3_state_e state_d;
    logic      from_restore_q;
    logic      from_restore_d;

    logic             idle_clr;
    logic             idle_hit;
    logic [CNT_W-1:0] idle_count;
    logic             settle_clr;
    logic             settle_done;
    logic [CNT_W-1:0] settle_count;

    // Idle counter: counts consecutive idle samples taken while in ACTIVE and
    // stays at zero in every other state, including the edge that leaves.
    assign idle_clr = !idle || (state_q != S_ACTIVE) || (state_d != S_ACTIVE);

    s3_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_idle_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (idle_clr),
        .en       (idle),
        .limit    (IDLE_TERM),
        .count    (idle_count),
        .at_limit (idle_hit)
    );

    // Settle counter: zero on the first POWER_UP cycle, one per cycle after,
    // and back to zero on the edge that leaves POWER_UP.
    assign settle_clr = (state_q != S_POWER_UP) || (state_d != S_POWER_UP);

    s3_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (settle_clr),
        .en       (1'b1),
        .limit    (SETTLE_TERM),
        .count    (settle_count),
        .at_limit (settle_done)
    );

    always_comb begin
        state_d        = state_q;
        from_restore_d = (state_q == S_RESTORE);
        case (state_q)
            S_ACTIVE: begin
                // The current idle sample completes the run when the count of
                // earlier samples already sits at IDLE_LIMIT-1.
                if (!wake_req && (sleep_req || (idle && idle_hit))) begin
                    state_d = S_SAVE;
                end
            end
            S_SAVE:  state_d = S_CLAMP;
            S_CLAMP: state_d = wake_req ? S_RELEASE : S_GATE;
            // Past the clamp the sequence is committed; wake is honoured in OFF.
            S_GATE:  state_d = S_OFF;
            S_OFF: begin
                if (wake_req) begin
                    state_d = S_POWER_UP;
                end
            end
            S_POWER_UP: begin
                if (settle_done) begin
                    state_d = S_RESTORE;
                end
            end
            S_RESTORE: state_d = S_RELEASE;
            S_RELEASE: state_d = S_ACTIVE;
            default:   state_d = S_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_ACTIVE;
            from_restore_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            from_restore_q <= from_restore_d;
        end
    end

    // Moore output decode. The clamp is applied one state before clock gating
    // and reset, and released one state after reset drops, so the isolation
    // boundary always brackets the unpowered interval.
    always_comb begin
        s3_state      = 1'b0;
        ram_we        = 1'b0;
        clk_gate      = 1'b0;
        iso_clampn    = 1'b1;
        reset_assert  = 1'b0;
        pg_down       = 1'b0;
        restore_valid = 1'b0;
        sleeping      = 1'b0;
        case (state_q)
            S_SAVE: begin
                s3_state = 1'b1;
                ram_we   = 1'b1;
            end
            S_CLAMP: begin
                s3_state   = 1'b1;
                iso_clampn = 1'b0;
            end
            S_GATE, S_POWER_UP: begin
                s3_state     = 1'b1;
                iso_clampn   = 1'b0;
                clk_gate     = 1'b1;
                reset_assert = 1'b1;
            end
            S_OFF: begin
                s3_state     = 1'b1;
                iso_clampn   = 1'b0;
                clk_gate     = 1'b1;
                reset_assert = 1'b1;
                pg_down      = 1'b1;
                sleeping     = 1'b1;
            end
            S_RESTORE: begin
                iso_clampn = 1'b0;
                ram_we     = 1'b1;
            end
            S_RELEASE: begin
                // An abort from CLAMP also passes through RELEASE, but no RAM
                // restore happened, so the pulse is suppressed.
                restore_valid = from_restore_q;
            end
            default: begin
            end
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_s3_sequencer.sv
// tb_s3_sequencer
// Directed scoreboard bench for s3_sequencer with default parameters
// (IDLE_LIMIT=10, SETTLE_CYCLES=4). Each stimulus step queues the state and
// outputs expected after the next clock edge; a monitor compares at negedge.
// Isolation ordering is checked every cycle, including random traffic.
module tb_s3_sequencer;
    import s3_pm_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       idle = 1'b0;
    logic       sleep_req = 1'b0;
    logic       wake_req = 1'b0;
    logic       s3_state, ram_we, clk_gate, iso_clampn, reset_assert;
    logic       pg_down, restore_valid, sleeping;
    logic [2:0] fsm_state;

    s3_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .idle          (idle),
        .sleep_req     (sleep_req),
        .wake_req      (wake_req),
        .s3_state      (s3_state),
        .ram_we        (ram_we),
        .clk_gate      (clk_gate),
        .iso_clampn    (iso_clampn),
        .reset_assert  (reset_assert),
        .pg_down       (pg_down),
        .restore_valid (restore_valid),
        .sleeping      (sleeping),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [7:0] outs;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_order = 1'b0;
    logic prev_iso = 1'b1;

    // Expected outputs per state, packed as
    // {s3_state, ram_we, clk_gate, iso_clampn, reset_assert, pg_down, restore_valid, sleeping}
    function automatic logic [7:0] exp_outs(input logic [2:0] st, input logic rv);
        case (st)
            ST_ACTIVE:   return 8'b0001_0000;
            ST_SAVE:     return 8'b1101_0000;
            ST_CLAMP:    return 8'b1000_0000;
            ST_GATE:     return 8'b1010_1000;
            ST_OFF:      return 8'b1010_1101;
            ST_POWER_UP: return 8'b1010_1000;
            ST_RESTORE:  return 8'b0100_0000;
            default:     return {6'b0001_00, rv, 1'b0};
        endcase
    endfunction

    task automatic step(input logic r, input logic s, input logic w, input logic i,
                        input logic [2:0] st, input logic rv, input string nm);
        exp_t e;
        reset     = r;
        sleep_req = s;
        wake_req  = w;
        idle      = i;
        e.cyc  = cyc + 1;
        e.st   = st;
        e.outs = exp_outs(st, rv);
        e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard compare plus ordering checks, sampled at negedge.
    initial forever begin
        exp_t       e;
        logic [7:0] act;
        @(negedge clk);
        act = {s3_state, ram_we, clk_gate, iso_clampn, reset_assert, pg_down, restore_valid, sleeping};
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if ({fsm_state, act} !== {e.st, e.outs}) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         e.name, cyc, fsm_state, act, e.st, e.outs);
            end
        end
        if (chk_order) begin
            n_vec++;
            if (pg_down && iso_clampn) begin
                n_err++;
                $display("FAIL order_pg_iso @cyc %0d: pg_down=1 with iso_clampn=1", cyc);
            end
            n_vec++;
            if (clk_gate && prev_iso) begin
                n_err++;
                $display("FAIL order_gate_iso @cyc %0d: clk_gate=1 with previous iso_clampn=1", cyc);
            end
        end
        prev_iso = iso_clampn;
    end

    initial begin
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, ST_ACTIVE, 0, "reset");
        chk_order = 1'b1;
        step(0, 0, 0, 0, ST_ACTIVE, 0, "quiet");

        // One-cycle sleep pulse: SAVE, CLAMP, GATE, OFF; wake in GATE ignored.
        step(0, 1, 0, 0, ST_SAVE,  0, "sleep_save");
        step(0, 0, 0, 0, ST_CLAMP, 0, "sleep_clamp");
        step(0, 0, 0, 0, ST_GATE,  0, "sleep_gate");
        step(0, 0, 1, 0, ST_OFF,   0, "gate_ignores_wake");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, ST_OFF, 0, "off_hold");

        // Wake: four POWER_UP cycles, RESTORE, RELEASE with pulse, ACTIVE.
        step(0, 0, 1, 0, ST_POWER_UP, 0, "wake_pu1");
        step(0, 1, 1, 0, ST_POWER_UP, 0, "pu_ignores_reqs");
        step(0, 0, 0, 0, ST_POWER_UP, 0, "wake_pu3");
        step(0, 0, 0, 0, ST_POWER_UP, 0, "wake_pu4");
        step(0, 0, 0, 0, ST_RESTORE,  0, "wake_restore");
        step(0, 0, 0, 0, ST_RELEASE,  1, "wake_release_rv");
        step(0, 0, 0, 0, ST_ACTIVE,   0, "wake_active");

        // Idle: 9 idle, 1 busy, then 10 idle -> SAVE after the 10th.
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1, ST_ACTIVE, 0, "idle_run1");
        step(0, 0, 0, 0, ST_ACTIVE, 0, "idle_break");
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1, ST_ACTIVE, 0, "idle_run2");
        step(0, 0, 0, 1, ST_SAVE,  0, "idle_entry");
        step(0, 0, 0, 0, ST_CLAMP, 0, "idle_clamp");

        // Wake in CLAMP aborts: RELEASE without pulse, back to ACTIVE.
        step(0, 0, 1, 0, ST_RELEASE, 0, "clamp_abort");
        step(0, 0, 0, 0, ST_ACTIVE,  0, "abort_active");

        // Sleep and wake together: wake wins.
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, ST_ACTIVE, 0, "sleep_wake_both");
        step(0, 1, 0, 0, ST_SAVE,  0, "sleep_level");
        step(0, 1, 0, 0, ST_CLAMP, 0, "level_clamp");
        step(0, 1, 0, 0, ST_GATE,  0, "level_gate");
        step(0, 1, 0, 0, ST_OFF,   0, "level_off");
        step(0, 0, 0, 0, ST_OFF,   0, "level_off_hold");

        // Reset in OFF.
        step(1, 0, 0, 0, ST_ACTIVE, 0, "reset_in_off");
        step(0, 0, 0, 0, ST_ACTIVE, 0, "after_reset_off");

        // Reset in POWER_UP.
        step(0, 1, 0, 0, ST_SAVE,     0, "pu_path_save");
        step(0, 0, 0, 0, ST_CLAMP,    0, "pu_path_clamp");
        step(0, 0, 0, 0, ST_GATE,     0, "pu_path_gate");
        step(0, 0, 0, 0, ST_OFF,      0, "pu_path_off");
        step(0, 0, 1, 0, ST_POWER_UP, 0, "pu_path_pu1");
        step(0, 0, 0, 0, ST_POWER_UP, 0, "pu_path_pu2");
        step(1, 0, 0, 0, ST_ACTIVE,   0, "reset_in_pu");
        step(0, 0, 0, 0, ST_ACTIVE,   0, "after_reset_pu");

        // Full cycle with sleep_req held: settle is a fresh 4 cycles after the
        // earlier reset, and the held request re-enters SAVE from ACTIVE.
        step(0, 1, 0, 0, ST_SAVE,  0, "held_save");
        step(0, 1, 0, 0, ST_CLAMP, 0, "held_clamp");
        step(0, 1, 0, 0, ST_GATE,  0, "held_gate");
        step(0, 1, 0, 0, ST_OFF,   0, "held_off");
        step(0, 1, 1, 0, ST_POWER_UP, 0, "held_pu1");
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, ST_POWER_UP, 0, "held_pu");
        step(0, 1, 0, 0, ST_RESTORE, 0, "held_restore");
        step(0, 1, 0, 0, ST_RELEASE, 1, "held_release_rv");
        step(0, 1, 0, 0, ST_ACTIVE,  0, "held_active");
        step(0, 1, 0, 0, ST_SAVE,    0, "held_reenter");
        step(0, 0, 0, 0, ST_CLAMP,   0, "held_reenter_clamp");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        // Random sleep/wake/idle traffic under the ordering checks.
        for (int k = 0; k < 400; k++) begin
            reset     = (k == 0) || ($urandom_range(0, 99) == 0);
            sleep_req = ($urandom_range(0, 2) == 0);
            wake_req  = ($urandom_range(0, 4) == 0);
            idle      = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/s3_sequencer.md
# s3_sequencer

Central S3 power-state sequencer for the ALU/RAM retention subsystem. It decides when to enter S3, either on a software request or after sustained ALU idleness. It then walks the save → isolate → clock-gate/reset → power-down sequence, and on wake reverses it through power-up settle → RAM restore → isolation release. It drives the `s3_state` and RAM write-enable inputs of the datapath and replaces the ad-hoc power-control outputs with one ordered FSM.

## Interface
Parameters:
- `IDLE_LIMIT`, default 10: consecutive idle cycles in ACTIVE that trigger automatic S3 entry (≥1).
- `SETTLE_CYCLES`, default 4: cycles spent in POWER_UP after `pg_down` drops (≥1).
- `CNT_W`, default 8: shared counter width; must hold max(`IDLE_LIMIT`, `SETTLE_CYCLES`).

Ports:
- `clk`  in  1  single clock; one clock domain.
- `reset`  in  1  reset is synchronous and active-high.
- `idle`  in  1  ALU idle indication.
- `sleep_req`  in  1  level request to enter S3.
- `wake_req`  in  1  level wake event.
- `s3_state`  out  1  to ALU/RAM; high = save/retain phase.
- `ram_we`  out  1  RAM write_enable (store when `s3_state`=1, retrieve when 0).
- `clk_gate`  out  1  gate datapath clock.
- `iso_clampn`  out  1  active-low isolation clamp (0 = clamped).
- `reset_assert`  out  1  hold datapath in reset.
- `pg_down`  out  1  power-gate switch off.
- `restore_valid`  out  1  one-cycle pulse: RAM outputs hold restored data.
- `sleeping`  out  1  high only in OFF.
- `fsm_state`  out  3  current state code (debug).

## Operation
- States and codes: ACTIVE=0, SAVE=1, CLAMP=2, GATE=3, OFF=4, POWER_UP=5, RESTORE=6, RELEASE=7.
- Outputs are pure decodes of the state register (Moore).
- Outputs by state (anything not listed is 0, except `iso_clampn`, which is 1 unless listed as 0):
  - SAVE: `s3_state`=1, `ram_we`=1.
  - CLAMP: `s3_state`=1, `iso_clampn`=0.
  - GATE: `s3_state`=1, `iso_clampn`=0, `clk_gate`=1, `reset_assert`=1.
  - OFF: as GATE, plus `pg_down`=1 and `sleeping`=1.
  - POWER_UP: `s3_state`=1, `iso_clampn`=0, `clk_gate`=1, `reset_assert`=1.
  - RESTORE: `iso_clampn`=0, `ram_we`=1.
  - RELEASE: `restore_valid`=1 only when entered from RESTORE.
- ACTIVE idle counter:
  - Increments (saturating) while `idle`=1 and clears on `idle`=0.
  - Cleared whenever the FSM is outside ACTIVE.
- ACTIVE → SAVE when `wake_req`=0 and either `sleep_req`=1, or `idle` has been 1 for `IDLE_LIMIT` consecutive sampled cycles.
- `wake_req`=1 blocks entry; wake has priority over a simultaneous sleep request.
- SAVE → CLAMP unconditionally.
- CLAMP → RELEASE if `wake_req`=1 (abort; no power-down, no restore pulse); otherwise CLAMP → GATE.
- GATE → OFF unconditionally; `wake_req` is ignored here.
- OFF holds until `wake_req`=1, then → POWER_UP.
- POWER_UP:
  - Settle counter loads 0 on entry.
  - Exits to RESTORE when the count reaches `SETTLE_CYCLES`-1, so the state lasts exactly `SETTLE_CYCLES` cycles.
  - `wake_req` and `sleep_req` are ignored.
- RESTORE → RELEASE; RELEASE → ACTIVE.
- `sleep_req` still high on return to ACTIVE re-enters SAVE on the next edge (level semantics).

## Timing
- Reset values:
  - FSM in ACTIVE; counters 0.
  - `iso_clampn`=1; all other outputs 0; `fsm_state`=0.
- Reset is sampled every edge and has priority in every state. From OFF, `pg_down` falls and `iso_clampn` rises in the cycle after the reset edge.
- Entry latency: `sleep_req` sampled at edge N →
  - SAVE in cycle N+1.
  - CLAMP in N+2.
  - GATE in N+3.
  - `pg_down`=1 from N+4.
- Idle entry: `idle` high from edge N continuously → SAVE in cycle N+`IDLE_LIMIT`.
  - A single `idle`=0 cycle restarts the count.
- Wake latency: `wake_req` sampled in OFF at edge M →
  - POWER_UP in cycles M+1 .. M+`SETTLE_CYCLES`.
  - RESTORE in M+`SETTLE_CYCLES`+1.
  - RELEASE (`restore_valid`=1) in M+`SETTLE_CYCLES`+2.
  - ACTIVE in M+`SETTLE_CYCLES`+3.
- Isolation ordering guarantees:
  - `iso_clampn` falls at least one cycle before `clk_gate`/`reset_assert` rise.
  - `iso_clampn` rises at least one cycle after `reset_assert` falls.
  - `pg_down` is never 1 while `iso_clampn`=1.

## Structure
- Package `s3_pm_pkg`:
  - state code localparams (3-bit) and `S3_STATE_W`=3.
  - default `IDLE_LIMIT`/`SETTLE_CYCLES` constants, shared with the datapath and bench.
- Sub-module `s3_cycle_counter`:
  - generic `CNT_W` counter with clear, enable, saturation and terminal-compare against a runtime limit.
  - Two instances: idle count and settle count.
- FSM and output decode live in `s3_sequencer`.

## Test plan
- Reset, then `sleep_req` pulse 1 cycle:
  - state sequence 0,1,2,3,4; `pg_down`=1 four cycles after the sample.
  - `sleeping`=1 and holds while `wake_req`=0.
- From OFF, `wake_req`=1 with `SETTLE_CYCLES`=4:
  - 4 cycles in POWER_UP, then RESTORE with `ram_we`=1, `s3_state`=0.
  - `restore_valid` pulse exactly 1 cycle, then ACTIVE.
- `idle`=1 for 9 cycles, 0 for 1, then 10 cycles (`IDLE_LIMIT`=10): no entry after the first run; SAVE follows the 10th idle cycle of the second run.
- `sleep_req` and `wake_req` high together in ACTIVE: remains ACTIVE. `wake_req`=1 in CLAMP: → RELEASE → ACTIVE with `restore_valid`=0 and `pg_down` never set.
- `reset` asserted in OFF and in POWER_UP: next cycle `fsm_state`=0, `pg_down`=0, `iso_clampn`=1, counters 0.
- Ordering assertion across random sleep/wake traffic: never `pg_down`=1 with `iso_clampn`=1; never `clk_gate`=1 in a cycle where `iso_clampn` was 1 in the previous cycle.
